// File: rtl/graph_key_fade_status.sv
// graph_key_fade_status
//   Per-key status store for the keyboard visualiser. Holds one instrument
//   mask per melodic key plus one drum row, per-key release fade timers,
//   the last instrument played on each key, and a self-clearing sweep that
//   runs after reset or on request. Reads go through a two-stage registered
//   pipeline that flags its result with rd_valid.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data : row write from the MIDI/track decoder
//                   (wr_addr == NUM_KEYS selects the drum row, above is ignored)
//   tick          : fade time base, one-cycle pulse per frame
//   clr           : one-cycle request for a full clear sweep
//   busy          : clear sweep in progress (writes and ticks dropped)
//   rd_en/rd_addr/rd_drum/drum_key/active_inst : lookup from the key renderer
//   rd_valid      : lookup result valid, two cycles after rd_en
//   out_active/out_inst/out_fade : decoded key status, held while rd_valid=0
module graph_key_fade_status #(
  parameter int NUM_KEYS  = 48,
  parameter int NUM_INST  = 8,
  parameter int NUM_DRUM  = 8,
  parameter int FADE_BITS = 4,
  localparam int AW = $clog2(NUM_KEYS + 1),
  localparam int IW = $clog2(NUM_INST),
  localparam int DW = $clog2(NUM_DRUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [NUM_INST-1:0]  wr_data,
  input  logic                 tick,
  input  logic                 clr,
  output logic                 busy,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  input  logic                 rd_drum,
  input  logic [DW-1:0]        drum_key,
  input  logic [IW-1:0]        active_inst,
  output logic                 rd_valid,
  output logic                 out_active,
  output logic [IW-1:0]        out_inst,
  output logic [FADE_BITS-1:0] out_fade
);

  localparam logic [FADE_BITS-1:0] FMAX     = {FADE_BITS{1'b1}};
  localparam logic [AW-1:0]        DRUM_ROW = AW'(NUM_KEYS);

  // Index of the lowest set bit of an instrument mask; 0 for an empty mask.
  function automatic logic [IW-1:0] lowest_bit(input logic [NUM_INST-1:0] m);
    logic [IW-1:0] r;
    r = '0;
    for (int b = NUM_INST - 1; b >= 0; b--) begin
      if (m[b]) begin
        r = IW'(b);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Storage
  logic [NUM_INST-1:0]  mask_mem [0:NUM_KEYS];
  logic [NUM_KEYS-1:0]  nz_q, nz_d;
  logic [FADE_BITS-1:0] fade_q [NUM_KEYS];
  logic [FADE_BITS-1:0] fade_d [NUM_KEYS];
  logic [IW-1:0]        last_q [NUM_KEYS];
  logic [IW-1:0]        last_d [NUM_KEYS];
  logic [NUM_DRUM-1:0]  dmask_q, dmask_d;
  logic [FADE_BITS-1:0] dfade_q [NUM_DRUM];
  logic [FADE_BITS-1:0] dfade_d [NUM_DRUM];

  // Sweep control
  logic          busy_q, busy_d;
  logic [AW-1:0] idx_q, idx_d;

  logic          wr_ok_s, tick_ok_s, drum_wr_s;
  logic          mask_we_s;
  logic [AW-1:0] mask_wa_s;
  logic [NUM_INST-1:0] mask_wd_s;

  assign wr_ok_s   = wr_en & ~busy_q;
  assign tick_ok_s = tick & ~busy_q;
  assign drum_wr_s = wr_ok_s & (wr_addr == DRUM_ROW);

  // The single mask write port is shared: the sweep owns it while busy.
  assign mask_we_s = busy_q | (wr_ok_s & (wr_addr <= DRUM_ROW));
  assign mask_wa_s = busy_q ? idx_q : wr_addr;
  assign mask_wd_s = busy_q ? {NUM_INST{1'b0}} : wr_data;

  // Next-state for sweep, key flags, fade timers and drum state.
  always_comb begin
    busy_d  = busy_q;
    idx_d   = idx_q;
    nz_d    = nz_q;
    dmask_d = dmask_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      fade_d[i] = fade_q[i];
      last_d[i] = last_q[i];
    end
    for (int j = 0; j < NUM_DRUM; j++) begin
      dfade_d[j] = dfade_q[j];
    end

    if (busy_q) begin
      // One row per cycle; the drum flops go with row 0.
      if (idx_q == DRUM_ROW) begin
        busy_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + AW'(1);
      end
      if (idx_q == AW'(0)) begin
        dmask_d = '0;
        for (int j = 0; j < NUM_DRUM; j++) begin
          dfade_d[j] = '0;
        end
      end else begin
        dmask_d = dmask_q;
      end
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (idx_q == AW'(i)) begin
          nz_d[i]   = 1'b0;
          fade_d[i] = '0;
          last_d[i] = '0;
        end else begin
          nz_d[i] = nz_q[i];
        end
      end
    end else begin
      if (clr) begin
        busy_d = 1'b1;
        idx_d  = '0;
      end else begin
        busy_d = 1'b0;
      end

      for (int i = 0; i < NUM_KEYS; i++) begin
        if (wr_ok_s && (wr_addr == AW'(i))) begin
          nz_d[i] = |wr_data;
          if (|wr_data) begin
            fade_d[i] = FMAX;
            last_d[i] = lowest_bit(wr_data);
          end else begin
            fade_d[i] = fade_q[i];
          end
        end else begin
          nz_d[i] = nz_q[i];
        end
        // Only rows idle both before and after this cycle decay, so a
        // fresh release keeps FMAX for its first tick.
        if (tick_ok_s && !nz_d[i] && !nz_q[i] && (fade_d[i] != '0)) begin
          fade_d[i] = fade_d[i] - FADE_BITS'(1);
        end else begin
          fade_d[i] = fade_d[i];
        end
      end

      for (int j = 0; j < NUM_DRUM; j++) begin
        if (drum_wr_s) begin
          dmask_d[j] = wr_data[j];
          if (wr_data[j]) begin
            dfade_d[j] = FMAX;
          end else begin
            dfade_d[j] = dfade_q[j];
          end
        end else begin
          dmask_d[j] = dmask_q[j];
        end
        if (tick_ok_s && !dmask_d[j] && !dmask_q[j] && (dfade_d[j] != '0)) begin
          dfade_d[j] = dfade_d[j] - FADE_BITS'(1);
        end else begin
          dfade_d[j] = dfade_d[j];
        end
      end
    end
  end

  // State registers; reset leaves busy set so the sweep starts on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b1;
      idx_q   <= '0;
      nz_q    <= '0;
      dmask_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        fade_q[i] <= '0;
        last_q[i] <= '0;
      end
      for (int j = 0; j < NUM_DRUM; j++) begin
        dfade_q[j] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      idx_q   <= idx_d;
      nz_q    <= nz_d;
      dmask_q <= dmask_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        fade_q[i] <= fade_d[i];
        last_q[i] <= last_d[i];
      end
      for (int j = 0; j < NUM_DRUM; j++) begin
        dfade_q[j] <= dfade_d[j];
      end
    end
  end

  // Mask RAM write port (no reset; the sweep initialises it).
  always_ff @(posedge clk) begin
    if (mask_we_s) begin
      mask_mem[mask_wa_s] <= mask_wd_s;
    end
  end

  // Read stage 1 registers
  logic                 s1_valid_q, s1_drum_q, s1_dbit_q;
  logic [NUM_INST-1:0]  s1_mask_q;
  logic [FADE_BITS-1:0] s1_fade_q;
  logic [IW-1:0]        s1_last_q, s1_ainst_q;
  logic                 rd_mel_ok_s;

  assign rd_mel_ok_s = (rd_addr < DRUM_ROW);

  // Stage 1: capture the addressed row (pre-write contents on a collision).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_drum_q  <= 1'b0;
      s1_dbit_q  <= 1'b0;
      s1_mask_q  <= '0;
      s1_fade_q  <= '0;
      s1_last_q  <= '0;
      s1_ainst_q <= '0;
    end else begin
      s1_valid_q <= rd_en;
      if (rd_en) begin
        s1_drum_q  <= rd_drum;
        s1_ainst_q <= active_inst;
        if (rd_drum) begin
          s1_mask_q <= '0;
          s1_last_q <= '0;
          s1_dbit_q <= dmask_q[drum_key];
          s1_fade_q <= dfade_q[drum_key];
        end else if (rd_mel_ok_s) begin
          s1_mask_q <= mask_mem[rd_addr];
          s1_last_q <= last_q[rd_addr];
          s1_dbit_q <= 1'b0;
          s1_fade_q <= fade_q[rd_addr];
        end else begin
          s1_mask_q <= '0;
          s1_last_q <= '0;
          s1_dbit_q <= 1'b0;
          s1_fade_q <= '0;
        end
      end
    end
  end

  // Stage 2 decode
  logic                 dec_active_s;
  logic [IW-1:0]        dec_inst_s;
  logic [FADE_BITS-1:0] dec_fade_s;

  // Decode the captured row into display status.
  always_comb begin
    dec_active_s = 1'b0;
    dec_inst_s   = '0;
    dec_fade_s   = '0;
    if (s1_drum_q) begin
      dec_active_s = s1_dbit_q;
      dec_inst_s   = '0;
      dec_fade_s   = s1_fade_q;
    end else begin
      dec_active_s = |s1_mask_q;
      if (dec_active_s) begin
        dec_fade_s = FMAX;
        // Prefer the renderer's instrument when it is sounding on this key.
        if ((int'(s1_ainst_q) < NUM_INST) && s1_mask_q[s1_ainst_q]) begin
          dec_inst_s = s1_ainst_q;
        end else begin
          dec_inst_s = lowest_bit(s1_mask_q);
        end
      end else begin
        dec_inst_s = s1_last_q;
        dec_fade_s = s1_fade_q;
      end
    end
  end

  logic                 rd_valid_q, out_active_q;
  logic [IW-1:0]        out_inst_q;
  logic [FADE_BITS-1:0] out_fade_q;

  // Stage 2 output registers; hold their value between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q   <= 1'b0;
      out_active_q <= 1'b0;
      out_inst_q   <= '0;
      out_fade_q   <= '0;
    end else begin
      rd_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_active_q <= dec_active_s;
        out_inst_q   <= dec_inst_s;
        out_fade_q   <= dec_fade_s;
      end
    end
  end

  assign busy       = busy_q;
  assign rd_valid   = rd_valid_q;
  assign out_active = out_active_q;
  assign out_inst   = out_inst_q;
  assign out_fade   = out_fade_q;

endmodule

// File: tb/tb_graph_key_fade_status.sv
// Self-checking bench for graph_key_fade_status (default parameters:
// 48 keys, 8 instruments, 8 drums, 4-bit fade).
module tb_graph_key_fade_status;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       tick;
  logic       clr;
  logic       busy;
  logic       rd_en;
  logic [5:0] rd_addr;
  logic       rd_drum;
  logic [2:0] drum_key;
  logic [2:0] active_inst;
  logic       rd_valid;
  logic       out_active;
  logic [2:0] out_inst;
  logic [3:0] out_fade;

  graph_key_fade_status dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .tick(tick), .clr(clr), .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_drum(rd_drum), .drum_key(drum_key), .active_inst(active_inst),
    .rd_valid(rd_valid), .out_active(out_active), .out_inst(out_inst), .out_fade(out_fade)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic       act;
    logic [2:0] inst;
    logic [3:0] fade;
    int         id;
  } exp_t;

  typedef struct {
    logic [5:0] addr;
    logic       drum;
    logic [2:0] dkey;
    logic [2:0] ainst;
    logic       act;
    logic [2:0] inst;
    logic [3:0] fade;
  } vec_t;

  exp_t sb[$];
  vec_t vt [9];
  vec_t vz [6];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rd_id    = 0;
  int n;

  task automatic chk(input string nm, input int id, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s (read %0d): got %0d expected %0d", nm, id, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] a, input logic d, input logic [2:0] dk,
                              input logic [2:0] ai, input logic ea, input logic [2:0] ei,
                              input logic [3:0] ef);
    vec_t v;
    v.addr = a; v.drum = d; v.dkey = dk; v.ainst = ai;
    v.act = ea; v.inst = ei; v.fade = ef;
    return v;
  endfunction

  // Scoreboard compare, called at the falling edge.
  task automatic sample();
    exp_t e;
    if (rd_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", -1, 1, 0);
      end else begin
        e = sb.pop_front();
        chk("latency", e.id, cyc, e.due);
        chk("out_active", e.id, int'(out_active), int'(e.act));
        chk("out_inst", e.id, int'(out_inst), int'(e.inst));
        chk("out_fade", e.id, int'(out_fade), int'(e.fade));
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("missing_valid", e.id, 0, 1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    wr_en = 1'b0; tick = 1'b0; clr = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    sample();
  endtask

  task automatic set_read(input vec_t v);
    exp_t e;
    rd_en = 1'b1; rd_addr = v.addr; rd_drum = v.drum;
    drum_key = v.dkey; active_inst = v.ainst;
    e.due = cyc + 2; e.act = v.act; e.inst = v.inst; e.fade = v.fade; e.id = rd_id;
    sb.push_back(e);
    rd_id++;
  endtask

  task automatic set_write(input logic [5:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic drain();
    for (int k = 0; k < 6 && sb.size() > 0; k++) step();
    chk("drain_timeout", rd_id, sb.size(), 0);
    sb.delete();
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    set_write(a, d);
    step();
  endtask

  task automatic rd(input vec_t v);
    set_read(v);
    step();
    drain();
  endtask

  task automatic tk(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      tick = 1'b1;
      step();
    end
  endtask

  initial begin
    rst_n = 1'b1;
    wr_en = 1'b0; wr_addr = 6'd0; wr_data = 8'h00; tick = 1'b0; clr = 1'b0;
    rd_en = 1'b0; rd_addr = 6'd0; rd_drum = 1'b0; drum_key = 3'd0; active_inst = 3'd0;

    // Back-to-back lookups against the state reached before the clear.
    vt[0] = mk(6'd5,  1'b0, 3'd0, 3'd0, 1'b0, 3'd2, 4'd0);
    vt[1] = mk(6'd7,  1'b0, 3'd0, 3'd0, 1'b0, 3'd7, 4'd13);
    vt[2] = mk(6'd9,  1'b0, 3'd0, 3'd0, 1'b0, 3'd1, 4'd1);
    vt[3] = mk(6'd10, 1'b0, 3'd0, 3'd5, 1'b1, 3'd0, 4'd15);
    vt[4] = mk(6'd10, 1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 4'd15);
    vt[5] = mk(6'd0,  1'b1, 3'd0, 3'd0, 1'b1, 3'd0, 4'd15);
    vt[6] = mk(6'd0,  1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 4'd13);
    vt[7] = mk(6'd0,  1'b1, 3'd1, 3'd0, 1'b0, 3'd0, 4'd0);
    vt[8] = mk(6'd0,  1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 4'd0);
    // Everything reads empty after the requested clear.
    vz[0] = mk(6'd5,  1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 4'd0);
    vz[1] = mk(6'd6,  1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 4'd0);
    vz[2] = mk(6'd7,  1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 4'd0);
    vz[3] = mk(6'd10, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 4'd0);
    vz[4] = mk(6'd0,  1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 4'd0);
    vz[5] = mk(6'd0,  1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 4'd0);

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 0, int'(busy), 1);
    chk("rst_rd_valid", 0, int'(rd_valid), 0);
    chk("rst_out_active", 0, int'(out_active), 0);
    chk("rst_out_inst", 0, int'(out_inst), 0);
    chk("rst_out_fade", 0, int'(out_fade), 0);
    step(); step(); step();
    rst_n = 1'b1;

    // Power-on sweep length
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk("reset_sweep_cycles", 0, n, 49);
    rd(mk(6'd0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 4'd0));

    // Active key, preferred vs lowest instrument
    wr(6'd5, 8'b0010_0100);
    rd(mk(6'd5, 1'b0, 3'd0, 3'd5, 1'b1, 3'd5, 4'd15));
    rd(mk(6'd5, 1'b0, 3'd0, 3'd3, 1'b1, 3'd2, 4'd15));

    // Release decay and saturation at zero
    wr(6'd5, 8'h00);
    tk(3);
    rd(mk(6'd5, 1'b0, 3'd0, 3'd0, 1'b0, 3'd2, 4'd12));
    tk(20);
    rd(mk(6'd5, 1'b0, 3'd0, 3'd0, 1'b0, 3'd2, 4'd0));

    // Release with tick in the same cycle vs an already idle row
    wr(6'd7, 8'h80);
    wr(6'd9, 8'h02);
    wr(6'd9, 8'h00);
    tk(11);
    rd(mk(6'd9, 1'b0, 3'd0, 3'd0, 1'b0, 3'd1, 4'd4));
    set_write(6'd7, 8'h00);
    tick = 1'b1;
    step();
    rd(mk(6'd7, 1'b0, 3'd0, 3'd0, 1'b0, 3'd7, 4'd15));
    rd(mk(6'd9, 1'b0, 3'd0, 3'd0, 1'b0, 3'd1, 4'd3));

    // Drum row
    wr(6'd48, 8'h09);
    wr(6'd48, 8'h01);
    tk(2);
    rd(mk(6'd0, 1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 4'd13));
    rd(mk(6'd0, 1'b1, 3'd0, 3'd0, 1'b1, 3'd0, 4'd15));

    // Read and write of the same row in one cycle returns the old row
    set_read(mk(6'd10, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 4'd0));
    set_write(6'd10, 8'h01);
    step();
    drain();
    rd(mk(6'd10, 1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 4'd15));

    // Table of back-to-back reads
    for (int i = 0; i < 9; i++) begin
      set_read(vt[i]);
      step();
    end
    drain();

    // Requested clear with a late write and tick that must be dropped
    wr(6'd5, 8'h24);
    clr = 1'b1;
    step();
    chk("busy_after_clr", 0, int'(busy), 1);
    n = 0;
    while (busy && n < 200) begin
      if (n == 40) begin
        set_write(6'd6, 8'hff);
        tick = 1'b1;
      end
      step();
      n++;
    end
    chk("clr_sweep_cycles", 0, n, 49);
    for (int i = 0; i < 6; i++) begin
      set_read(vz[i]);
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
